sram_port_arbiter: RTL

- Shares the single 16-bit asynchronous board SRAM between the instruction-fetch port and the data-memory port.
- Each requester sees a 32-bit word interface. The block splits every word access into two half-word SRAM cycles, low half first.
- Sits between the pipeline's fetch/memory stages and the SRAM pins. It owns all SRAM control, address and dq-tristate signals.

---
 rtl/sram_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit asynchronous SRAM between an instruction-read port and a data port,
// splitting each 32-bit access into two half-word cycles. Optional: SRAM_ARB_ROUND_ROBIN_EN.
module sram_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int WORD_ADDR_WIDTH = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req,
  input  logic [WORD_ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0]      i_rdata,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [DATA_WIDTH/8-1:0]    d_be,
  input  logic [WORD_ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wdata,
  output logic [DATA_WIDTH-1:0]      d_rdata,
  output logic                       d_done,
  output logic                       busy,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] sram_dq,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_lb_n,
  output logic                       sram_ub_n
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int HALF_BE  = BE_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                       state, state_next;
  logic [WORD_ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]        lat_wdata;
  logic [BE_WIDTH-1:0]          lat_be;
  logic                         lat_we;
  logic                         grant_d;
  logic                         pick_d;
  logic [SRAM_DATA_WIDTH-1:0]   rd_lo;
  logic                         hi_half;
  logic [HALF_BE-1:0]           half_be;
  logic                         dq_oe;
  logic [SRAM_DATA_WIDTH-1:0]   dq_out;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie the port that lost last time wins; a lone request always wins.
  always_comb begin
    pick_d = d_req;
    if (d_req && i_req) pick_d = !last_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               last_d <= 1'b1;
    else if (state == IDLE && (i_req || d_req)) last_d <= pick_d;
  end
`else
  always_comb pick_d = d_req;
`endif

  // NOTE: state and datapath flops use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_we    <= 1'b0;
      grant_d   <= 1'b0;
      rd_lo     <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (i_req || d_req) begin
          grant_d   <= pick_d;
          lat_addr  <= pick_d ? d_addr : i_addr;
          lat_wdata <= pick_d ? d_wdata : '0;
          lat_be    <= pick_d ? d_be : '1;
          lat_we    <= pick_d & d_we;
        end
        LO: if (!lat_we) rd_lo <= sram_dq;
        HI: if (!lat_we) begin
          if (grant_d) d_rdata <= {sram_dq, rd_lo};
          else         i_rdata <= {sram_dq, rd_lo};
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    hi_half    = (state == HI);
    half_be    = '0;
    sram_addr  = '0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;
    dq_oe      = 1'b0;
    dq_out     = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (i_req || d_req) state_next = LO;
      LO, HI: begin
        half_be   = hi_half ? lat_be[BE_WIDTH-1 -: HALF_BE] : lat_be[HALF_BE-1:0];
        sram_addr = {lat_addr, hi_half};
        sram_ce_n = 1'b0;
        if (lat_we) begin
          // A write half with no enabled bytes still drives dq but never pulses we_n.
          dq_oe     = 1'b1;
          dq_out    = hi_half ? lat_wdata[DATA_WIDTH-1 -: SRAM_DATA_WIDTH]
                              : lat_wdata[SRAM_DATA_WIDTH-1:0];
          sram_lb_n = ~half_be[0];
          sram_ub_n = ~half_be[1];
          sram_we_n = ~(|half_be);
        end else begin
          sram_oe_n = 1'b0;
          sram_lb_n = 1'b0;
          sram_ub_n = 1'b0;
        end
        state_next = hi_half ? DONE : HI;
      end
      DONE: begin
        d_done     = grant_d;
        i_done     = !grant_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_dq = dq_oe ? dq_out : {SRAM_DATA_WIDTH{1'bz}};

endmodule
